// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I/D request, hit/load and RAM port bundle for mem_arbiter
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;

    // arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // pipeline + RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single RAM port arbiter between instruction fetch and data access
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        IBUSY,
        DBUSY,
        IRESP,
        DRESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  streak;
    logic [31:0] lat_addr;
    logic [31:0] lat_store;
    logic        lat_write;
    logic [31:0] iload_r;
    logic [31:0] dload_r;

    logic        d_pend;
    logic        i_pend;
    logic        starved;
    logic        grant_d;
    logic        grant_i;
    logic        still_req;

    // Data wins unless fetch has already lost STARVE_MAX times in a row.
    always_comb begin
        d_pend  = bus.dREN | bus.dWEN;
        i_pend  = bus.iREN;
        starved = (streak == STREAK_MAX);
        grant_d = d_pend & ~(i_pend & starved);
        grant_i = i_pend & ~grant_d;
        // A write-latched access is owned by dWEN (write wins when both are high).
        if (state == IBUSY) begin
            still_req = bus.iREN;
        end else if (lat_write) begin
            still_req = bus.dWEN;
        end else begin
            still_req = bus.dREN;
        end
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all port outputs, driven purely from the state and latched request.
    always_comb begin
        state_next   = state;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'h0;
        bus.ramstore = 32'h0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.iload    = iload_r;
        bus.dload    = dload_r;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = DBUSY;
                end else if (grant_i) begin
                    state_next = IBUSY;
                end
            end
            IBUSY: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = lat_addr;
                if (bus.ramready) begin
                    state_next = still_req ? IRESP : IDLE;
                end
            end
            DBUSY: begin
                bus.ramREN   = ~lat_write;
                bus.ramWEN   = lat_write;
                bus.ramaddr  = lat_addr;
                bus.ramstore = lat_store;
                if (bus.ramready) begin
                    state_next = still_req ? DRESP : IDLE;
                end
            end
            IRESP: begin
                bus.ihit   = 1'b1;
                state_next = IDLE;
            end
            DRESP: begin
                bus.dhit   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the granted request and track consecutive data wins over a waiting fetch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_addr  <= 32'h0;
            lat_store <= 32'h0;
            lat_write <= 1'b0;
            streak    <= 4'h0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                lat_addr  <= bus.daddr;
                lat_store <= bus.dstore;
                lat_write <= bus.dWEN;
                if (!i_pend) begin
                    streak <= 4'h0;
                end else if (!starved) begin
                    streak <= streak + 4'h1;
                end
            end else if (grant_i) begin
                lat_addr  <= bus.iaddr;
                lat_write <= 1'b0;
                streak    <= 4'h0;
            end
        end
    end

    // Capture read data on completion, but only for a requester still waiting for it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iload_r <= 32'h0;
            dload_r <= 32'h0;
        end else if (bus.ramready && still_req) begin
            if (state == IBUSY) begin
                iload_r <= bus.ramload;
            end else if (state == DBUSY && !lat_write) begin
                dload_r <= bus.ramload;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single RAM port between instruction fetch (I) and data access (D) in the pipelined MIPS core.
- Produces the ihit/dhit pulses that the hazard control unit consumes for pipeline enables and stalls.
- Data requests normally win, with a bounded-starvation guarantee for fetch.
- Read data is registered and returned one cycle after the RAM completes.

Parameters:
- STARVE_MAX, 4: maximum consecutive D grants while I is pending before I is forced; range 1..15.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- iREN  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction word address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  one-cycle pulse, instruction access complete
- iload  out  32  registered instruction word, valid while ihit=1
- dhit  out  1  one-cycle pulse, data access complete
- dload  out  32  registered read data, valid while dhit=1 after a read
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramready  in  1  RAM completes the current access this cycle

Behaviour:
- Reset clears all outputs and registers to 0; the FSM goes to IDLE and the streak counter to 0. Reset asserted mid-access abandons the access immediately: no hit is issued and the RAM strobes drop asynchronously.
- Only one requester is granted in any cycle.
- FSM states:
  - IDLE: no strobes. Grant on the clock edge per the arbitration rule, latching the granted address, dstore and the op (read or write). Go to IBUSY or DBUSY; stay in IDLE if nothing is pending.
  - IBUSY: ramREN=1 and ramaddr=latched iaddr. On ramready, capture ramload into iload and go to IRESP.
  - DBUSY: ramREN or ramWEN per the latched op, ramaddr=latched daddr, ramstore=latched dstore. On ramready, capture ramload into dload on reads (dload unchanged on writes) and go to DRESP.
  - IRESP: ihit=1 for exactly one cycle, then IDLE.
  - DRESP: dhit=1 for exactly one cycle, then IDLE.
- Arbitration in IDLE:
  - D pending (dREN|dWEN) and I not pending: grant D.
  - I pending and D not pending: grant I.
  - Both pending: grant D unless streak==STARVE_MAX, in which case grant I.
- Streak counter:
  - Increments on each D grant made while iREN=1, saturating at STARVE_MAX.
  - Clears on any I grant.
  - Clears on a D grant with iREN=0.
- dREN and dWEN both high is illegal. The arbiter treats it as a write; the write wins.
- Latency: request visible at edge N puts the strobes up in cycle N+1. ramready in cycle M produces the hit in cycle M+1. The minimum request-to-hit time is 2 cycles. Because each access returns through IDLE, there is at least one idle cycle between accesses.
- Request withdrawn mid-access (granted enable drops in BUSY): the RAM access still completes. On ramready the FSM goes straight to IDLE and no hit is issued. A withdrawn read does not update its load register.
- Requester input changes (address, store data) after the grant are ignored; the latched values drive the RAM.
- ihit and dhit are never high in the same cycle. A hit is never asserted without a preceding ramready.
- RAM strobes are 0 in IDLE, IRESP and DRESP.

Test Plan:
- Reset, then iREN=1 with iaddr=0x40 and ramready asserted 1 cycle after ramREN -> ramaddr=0x40 in the cycle after the request; ihit pulses once with iload=ramload (e.g. 0x8C220004).
- iREN and dREN held together, 20 requests each, ramready immediate, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I,...; no requester waits more than 5 grants.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ramready delayed 3 cycles -> ramWEN high 4 cycles with ramstore=0xDEADBEEF; one dhit; dload unchanged.
- dREN dropped during DBUSY -> access completes on ramready, no dhit, FSM returns to IDLE, next iREN is served normally.
- RST pulsed during IBUSY -> strobes drop asynchronously, ihit stays 0, the FSM restarts in IDLE, streak=0.
- dREN and dWEN both high -> write performed (ramWEN=1, ramREN=0); a single dhit.
